// File: rtl/crc_chk_pkg.sv
// Shared definitions for the CRC lane checker.
//   CRC32_RESIDUE : residue left by CRC-32 run over data plus its own FCS
//   mode_e        : check-mode encoding (reserved code behaves as residue)
//   popcount      : ones count of a lane vector (up to MAX_LANES lanes)
//   sat_add       : counter add that clamps at a caller-supplied maximum
package crc_chk_pkg;

  localparam logic [31:0] CRC32_RESIDUE = 32'h1CDF4421;
  localparam int          MAX_LANES     = 16;

  typedef enum logic [1:0] {
    MODE_RES  = 2'd0,
    MODE_REF  = 2'd1,
    MODE_BOTH = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  function automatic logic [4:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Values are carried at 64 bits so one function serves every counter width;
  // the 65-bit sum catches carry-out when the counter itself is 64 bits wide.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [4:0]  inc,
                                          input logic [63:0] max_val);
    logic [64:0] sum;
    sum = {1'b0, a} + 65'(inc);
    if (sum > {1'b0, max_val}) return max_val;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/crc_ref_fifo.sv
// Reference-CRC FIFO for the lane checker.
// One push per cycle, RD_PORTS entries visible in parallel starting at the
// read pointer (slot i = entry rd_ptr+i), and a variable pop of 0..RD_PORTS.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_flush         : empty the FIFO (dominates push and pop)
//   i_push          : push request, i_push_data is the value
//   i_pop_cnt       : entries to retire this cycle (caller keeps it <= count)
//   o_rd_win        : RD_PORTS read slots, slot i at [CRC_W*(i+1)-1 -: CRC_W]
//   o_count         : current occupancy
//   o_push_drop     : push requested but no room after this cycle's pops
module crc_ref_fifo
  import crc_chk_pkg::*;
#(
  parameter int CRC_W    = 32,
  parameter int DEPTH    = 16,
  parameter int RD_PORTS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [CRC_W-1:0]          i_push_data,
  input  logic [4:0]                i_pop_cnt,
  output logic [RD_PORTS*CRC_W-1:0] o_rd_win,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [CRC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  logic [AW:0]      w_after_pop;
  logic             w_push_ok;

  // Room is judged after this cycle's pops, so a full FIFO can take a push
  // in the same cycle it retires an entry.
  assign w_after_pop = r_count - (AW+1)'(i_pop_cnt);
  assign w_push_ok   = i_push && (int'(w_after_pop) < DEPTH);
  assign o_push_drop = i_push && !w_push_ok;
  assign o_count     = r_count;

  // Pointers are AW bits wide and DEPTH is a power of two, so the address
  // sum wraps modulo DEPTH on its own.
  always_comb begin
    o_rd_win = '0;
    for (int i = 0; i < RD_PORTS; i++)
      o_rd_win[CRC_W*i +: CRC_W] = r_mem[r_rd_ptr + AW'(i)];
  end

  // NOTE: the storage array has no reset; occupancy guards every read, so
  // stale contents are never observed and the array stays plain registers.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(i_pop_cnt);
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count  <= w_after_pop + (AW+1)'(w_push_ok);
    end
  end

endmodule

// File: rtl/crc_lane_checker.sv
// Result checker for the segmented multi-lane CRC datapath.
// Residue mode checks each finished lane CRC against RESIDUE; reference mode
// compares lanes, in packet order, against a FIFO of serial-engine results.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clr            : clear counters, ovf and FIFO (err_vec still produced)
//   mode           : 0 residue, 1 reference, 2 both, 3 as 0
//   lane_en        : per-lane valid; lane_crc holds LANES packed results
//   ref_en/ref_crc : reference push
//   err_vec/err_any: registered per-lane error and its OR
//   pkt_cnt, res_err_cnt, mism_cnt, unmatched_cnt : saturating counters
//   ovf            : sticky dropped-push flag
//   fifo_level     : reference FIFO occupancy
module crc_lane_checker
  import crc_chk_pkg::*;
#(
  parameter int               LANES      = 8,
  parameter int               CRC_W      = 32,
  parameter logic [CRC_W-1:0] RESIDUE    = CRC_W'(CRC32_RESIDUE),
  parameter int               FIFO_DEPTH = 16,
  parameter int               CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [1:0]                  mode,
  input  logic [LANES-1:0]            lane_en,
  input  logic [LANES*CRC_W-1:0]      lane_crc,
  input  logic                        ref_en,
  input  logic [CRC_W-1:0]            ref_crc,
  output logic [LANES-1:0]            err_vec,
  output logic                        err_any,
  output logic [CNT_W-1:0]            pkt_cnt,
  output logic [CNT_W-1:0]            res_err_cnt,
  output logic [CNT_W-1:0]            mism_cnt,
  output logic [CNT_W-1:0]            unmatched_cnt,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

  mode_e                  w_mode;
  logic                   w_res_on;
  logic                   w_ref_on;
  logic [LANES*CRC_W-1:0] w_ref_win;
  logic [AW:0]            w_count;
  logic                   w_push_drop;
  logic [4:0]             w_pops;
  logic [LANES-1:0]       w_res_fail;
  logic [LANES-1:0]       w_mism;
  logic [LANES-1:0]       w_unm;
  logic [LANES-1:0]       w_err;

  logic [LANES-1:0]       r_err_vec;
  logic                   r_err_any;
  logic [CNT_W-1:0]       r_pkt_cnt;
  logic [CNT_W-1:0]       r_res_err_cnt;
  logic [CNT_W-1:0]       r_mism_cnt;
  logic [CNT_W-1:0]       r_unm_cnt;
  logic                   r_ovf;

  assign w_mode   = mode_e'(mode);
  assign w_res_on = (w_mode != MODE_REF);
  assign w_ref_on = (w_mode == MODE_REF) || (w_mode == MODE_BOTH);

  crc_ref_fifo #(
    .CRC_W    (CRC_W),
    .DEPTH    (FIFO_DEPTH),
    .RD_PORTS (LANES)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (clr),
    .i_push      (ref_en && !clr),
    .i_push_data (ref_crc),
    .i_pop_cnt   (clr ? 5'd0 : w_pops),
    .o_rd_win    (w_ref_win),
    .o_count     (w_count),
    .o_push_drop (w_push_drop)
  );

  // Lanes are ranked by ascending index among enabled lanes; rank r pairs
  // with FIFO slot r. Lanes ranked beyond the occupancy are unmatched and
  // do not pop, so actual pops = min(enabled lanes, occupancy).
  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    int rank;
    int avail;
    w_res_fail = '0;
    w_mism     = '0;
    w_unm      = '0;
    w_pops     = '0;
    rank       = 0;
    avail      = int'(w_count);
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k]) begin
        if (w_res_on && (lane_crc[CRC_W*k +: CRC_W] != RESIDUE))
          w_res_fail[k] = 1'b1;
        if (w_ref_on) begin
          if (rank < avail) begin
            if (lane_crc[CRC_W*k +: CRC_W] != w_ref_win[CRC_W*rank +: CRC_W])
              w_mism[k] = 1'b1;
          end else begin
            w_unm[k] = 1'b1;
          end
        end
        rank = rank + 1;
      end
    end
    if (w_ref_on) w_pops = 5'((rank < avail) ? rank : avail);
  end

  assign w_err = w_res_fail | w_mism | w_unm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_vec     <= '0;
      r_err_any     <= 1'b0;
      r_pkt_cnt     <= '0;
      r_res_err_cnt <= '0;
      r_mism_cnt    <= '0;
      r_unm_cnt     <= '0;
      r_ovf         <= 1'b0;
    end else begin
      // Error flags are produced even in a clear cycle; only the
      // statistics ignore that cycle's inputs.
      r_err_vec <= w_err;
      r_err_any <= |w_err;
      if (clr) begin
        r_pkt_cnt     <= '0;
        r_res_err_cnt <= '0;
        r_mism_cnt    <= '0;
        r_unm_cnt     <= '0;
        r_ovf         <= 1'b0;
      end else begin
        r_pkt_cnt     <= CNT_W'(sat_add(64'(r_pkt_cnt),
                                        popcount(MAX_LANES'(lane_en)), CNT_MAX));
        r_res_err_cnt <= CNT_W'(sat_add(64'(r_res_err_cnt),
                                        popcount(MAX_LANES'(w_res_fail)), CNT_MAX));
        r_mism_cnt    <= CNT_W'(sat_add(64'(r_mism_cnt),
                                        popcount(MAX_LANES'(w_mism)), CNT_MAX));
        r_unm_cnt     <= CNT_W'(sat_add(64'(r_unm_cnt),
                                        popcount(MAX_LANES'(w_unm)), CNT_MAX));
        if (w_push_drop) r_ovf <= 1'b1;
      end
    end
  end

  assign err_vec       = r_err_vec;
  assign err_any       = r_err_any;
  assign pkt_cnt       = r_pkt_cnt;
  assign res_err_cnt   = r_res_err_cnt;
  assign mism_cnt      = r_mism_cnt;
  assign unmatched_cnt = r_unm_cnt;
  assign ovf           = r_ovf;
  assign fifo_level    = w_count;

endmodule
